// File: rtl/evict_buffer.sv
// Write-back eviction buffer: FIFO of dirty lines with tag coalescing, snoop lookup
// and a two-state writer that drains the oldest line to memory.
module evict_buffer #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       evict_req,
    input  logic [15:0]                evict_addr,
    input  logic [WIDTH-1:0]           evict_data,
    output logic                       evict_ready,
    input  logic [15:0]                snoop_addr,
    output logic                       snoop_hit,
    output logic [WIDTH-1:0]           snoop_data,
    output logic                       pmem_write,
    output logic [15:0]                pmem_address,
    output logic [WIDTH-1:0]           pmem_wdata,
    input  logic                       pmem_resp,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state, state_nxt;
    logic [DEPTH-1:0]  valid;
    logic [11:0]       tags  [DEPTH];
    logic [WIDTH-1:0]  lines [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count_q;

    logic              push_fire, pop_fire, co_hit, alloc;
    logic [PW-1:0]     co_idx, co_scan, sn_scan;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{evict_addr[3:0], snoop_addr[3:0]};

    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign evict_ready  = !full;
    assign pmem_write   = (state == WRITE);
    assign pmem_address = pmem_write ? {tags[head], 4'b0000} : '0;
    assign pmem_wdata   = pmem_write ? lines[head] : '0;

    assign push_fire = evict_req && evict_ready;
    assign pop_fire  = (state == WRITE) && pmem_resp;
    assign alloc     = push_fire && !co_hit;

    // Scan oldest to youngest so the last match wins; the head being written is
    // excluded from coalescing so the line on the bus stays stable.
    always_comb begin
        co_hit  = 1'b0;
        co_idx  = '0;
        co_scan = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            co_scan = head + PW'(k);
            if (valid[co_scan] && tags[co_scan] == evict_addr[15:4] &&
                !(state == WRITE && k == 0)) begin
                co_hit = 1'b1;
                co_idx = co_scan;
            end
        end
    end

    always_comb begin
        snoop_hit  = 1'b0;
        snoop_data = '0;
        sn_scan    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            sn_scan = head + PW'(k);
            if (valid[sn_scan] && tags[sn_scan] == snoop_addr[15:4]) begin
                snoop_hit  = 1'b1;
                snoop_data = lines[sn_scan];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count_q != '0) state_nxt = WRITE;
            WRITE:   if (pmem_resp)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            valid   <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tags[i]  <= '0;
                lines[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (pop_fire) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (push_fire) begin
                if (co_hit) begin
                    lines[co_idx] <= evict_data;
                end else begin
                    valid[tail] <= 1'b1;
                    tags[tail]  <= evict_addr[15:4];
                    lines[tail] <= evict_data;
                    tail        <= tail + PW'(1);
                end
            end
            case ({alloc, pop_fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
